// File: rtl/sentence_builder.sv
// Sentence builder: packs a stream of ASCII characters into an 8-word x 4-char
// sentence buffer. It handles word separation, backspace and terminators, and
// holds the completed sentence until the consumer acknowledges it.
module sentence_builder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [7:0]   char_in,
    input  logic         char_valid,
    output logic         char_ready,
    output logic [255:0] sentence,
    output logic         sentence_valid,
    input  logic         sentence_ack,
    output logic [3:0]   word_count,
    output logic         overflow
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [255:0] BLANK = {32{8'h20}};

    state_t         state_r, state_s;
    logic [2:0]     word_idx_r, word_idx_s;
    logic [2:0]     char_pos_r, char_pos_s;
    logic [7:0][2:0] len_r, len_s;
    logic [255:0]   sentence_r, sentence_s;
    logic           overflow_r, overflow_s;
    logic [3:0]     word_count_r, word_count_s;
    logic           char_ready_r, sentence_valid_r;
    logic           accept_s, printable_s;

    // Bit offset of the LSB of slot (w,p); slot 0 sits at the top of the bus.
    function automatic logic [7:0] slot_lsb(input logic [2:0] w, input logic [1:0] p);
        return 8'd248 - {w, p, 3'b000};
    endfunction

    // Next-state and datapath decode for one accepted character or a clear/ack.
    always_comb begin
        state_s      = state_r;
        word_idx_s   = word_idx_r;
        char_pos_s   = char_pos_r;
        len_s        = len_r;
        sentence_s   = sentence_r;
        overflow_s   = overflow_r;
        accept_s     = char_valid && (state_r == FILL);
        printable_s  = (char_in >= 8'h21) && (char_in <= 8'h7E);

        if (clear || ((state_r == DONE) && sentence_ack)) begin
            state_s    = FILL;
            word_idx_s = 3'd0;
            char_pos_s = 3'd0;
            len_s      = '0;
            sentence_s = BLANK;
            overflow_s = 1'b0;
        end else if (accept_s) begin
            if (printable_s) begin
                if (char_pos_r < 3'd4) begin
                    sentence_s[slot_lsb(word_idx_r, char_pos_r[1:0]) +: 8] = char_in;
                    char_pos_s          = char_pos_r + 3'd1;
                    len_s[word_idx_r]   = char_pos_r + 3'd1;
                end else if (word_idx_r != 3'd7) begin
                    // Word full: wrap into the next word rather than dropping.
                    sentence_s[slot_lsb(word_idx_r + 3'd1, 2'd0) +: 8] = char_in;
                    word_idx_s               = word_idx_r + 3'd1;
                    char_pos_s               = 3'd1;
                    len_s[word_idx_r + 3'd1] = 3'd1;
                end else begin
                    overflow_s = 1'b1;
                end
            end else if (char_in == 8'h20) begin
                if ((char_pos_r != 3'd0) && (word_idx_r != 3'd7)) begin
                    word_idx_s = word_idx_r + 3'd1;
                    char_pos_s = 3'd0;
                end else begin
                    char_pos_s = char_pos_r;
                end
            end else if (char_in == 8'h08) begin
                if (char_pos_r != 3'd0) begin
                    sentence_s[slot_lsb(word_idx_r, char_pos_r[1:0] - 2'd1) +: 8] = 8'h20;
                    char_pos_s        = char_pos_r - 3'd1;
                    len_s[word_idx_r] = char_pos_r - 3'd1;
                end else if (word_idx_r != 3'd0) begin
                    // Step back to the end of the previous word; nothing erased.
                    word_idx_s = word_idx_r - 3'd1;
                    char_pos_s = len_r[word_idx_r - 3'd1];
                end else begin
                    char_pos_s = char_pos_r;
                end
            end else if ((char_in == 8'h0A) || (char_in == 8'h0D)) begin
                if (word_count_r != 4'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end else begin
                state_s = state_r;
            end
        end else begin
            state_s = state_r;
        end

        word_count_s = {1'b0, word_idx_s} + {3'b000, (char_pos_s != 3'd0)};
    end

    // State, buffer and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= FILL;
            word_idx_r       <= 3'd0;
            char_pos_r       <= 3'd0;
            len_r            <= '0;
            sentence_r       <= BLANK;
            overflow_r       <= 1'b0;
            word_count_r     <= 4'd0;
            char_ready_r     <= 1'b1;
            sentence_valid_r <= 1'b0;
        end else begin
            state_r          <= state_s;
            word_idx_r       <= word_idx_s;
            char_pos_r       <= char_pos_s;
            len_r            <= len_s;
            sentence_r       <= sentence_s;
            overflow_r       <= overflow_s;
            word_count_r     <= word_count_s;
            char_ready_r     <= (state_s == FILL);
            sentence_valid_r <= (state_s == DONE);
        end
    end

    assign char_ready     = char_ready_r;
    assign sentence       = sentence_r;
    assign sentence_valid = sentence_valid_r;
    assign word_count     = word_count_r;
    assign overflow       = overflow_r;

endmodule

// File: tb/tb_sentence_builder.sv
// Directed bench for sentence_builder: a table of single-cycle steps with
// hand-computed expectations, plus sequences for overflow, DONE hold, reset
// and clear corner cases.
module tb_sentence_builder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic [7:0]   char_in;
    logic         char_valid;
    logic         char_ready;
    logic [255:0] sentence;
    logic         sentence_valid;
    logic         sentence_ack;
    logic [3:0]   word_count;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] BLANK = {32{8'h20}};
    localparam logic [31:0]  SP4   = 32'h20202020;

    typedef struct {
        logic        v;
        logic [7:0]  ch;
        logic        ack;
        logic        clr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [3:0]  wc;
        logic        ovf;
        logic        sv;
    } vec_t;

    vec_t tbl[$];

    sentence_builder dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .char_in(char_in),
        .char_valid(char_valid), .char_ready(char_ready), .sentence(sentence),
        .sentence_valid(sentence_valid), .sentence_ack(sentence_ack),
        .word_count(word_count), .overflow(overflow)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [7:0] ch, logic ack, logic clr,
                                logic [31:0] w0, logic [31:0] w1, logic [3:0] wc,
                                logic ovf, logic sv);
        vec_t r;
        r.v = v; r.ch = ch; r.ack = ack; r.clr = clr;
        r.w0 = w0; r.w1 = w1; r.wc = wc; r.ovf = ovf; r.sv = sv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [3:0] wc, input logic ovf, input logic sv);
        chk({tag, " word_count"}, {252'd0, word_count}, {252'd0, wc});
        chk({tag, " overflow"}, {255'd0, overflow}, {255'd0, ovf});
        chk({tag, " sentence_valid"}, {255'd0, sentence_valid}, {255'd0, sv});
        chk({tag, " char_ready"}, {255'd0, char_ready}, {255'd0, ~sv});
    endtask

    // One clock of stimulus; inputs return low 1 unit after the edge.
    task automatic step(input logic v, input logic [7:0] ch, input logic ack, input logic clr);
        char_valid = v; char_in = ch; sentence_ack = ack; clear = clr;
        @(posedge clk);
        #1;
        char_valid = 1'b0; sentence_ack = 1'b0; clear = 1'b0; char_in = 8'h00;
    endtask

    task automatic send(input logic [7:0] ch);
        step(1'b1, ch, 1'b0, 1'b0);
    endtask

    initial begin
        logic [255:0] exp_s;
        logic [255:0] held_s;
        rst_n = 1'b0; clear = 1'b0; char_in = 8'h00; char_valid = 1'b0; sentence_ack = 1'b0;

        // "HI" space "YO" CR, then DONE ignores chars, then ack
        tbl.push_back(mk(1, 8'h48, 0, 0, 32'h48202020, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h49, 0, 0, 32'h48492020, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 32'h48492020, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, 32'h48492020, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h59, 0, 0, 32'h48492020, 32'h59202020, 4'd2, 0, 0));
        tbl.push_back(mk(1, 8'h4F, 0, 0, 32'h48492020, 32'h594F2020, 4'd2, 0, 0));
        tbl.push_back(mk(1, 8'h0D, 0, 0, 32'h48492020, 32'h594F2020, 4'd2, 0, 1));
        tbl.push_back(mk(1, 8'h5A, 0, 0, 32'h48492020, 32'h594F2020, 4'd2, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, SP4, SP4, 4'd0, 0, 0));
        // "ABCDE" with wrap, then three backspaces, then 'Z' lands at (0,3)
        tbl.push_back(mk(1, 8'h41, 0, 0, 32'h41202020, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h42, 0, 0, 32'h41422020, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h43, 0, 0, 32'h41424320, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h44, 0, 0, 32'h41424344, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h45, 0, 0, 32'h41424344, 32'h45202020, 4'd2, 0, 0));
        tbl.push_back(mk(1, 8'h08, 0, 0, 32'h41424344, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h08, 0, 0, 32'h41424344, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h08, 0, 0, 32'h41424320, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h5A, 0, 0, 32'h4142435A, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h07, 0, 0, 32'h4142435A, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'hC1, 0, 0, 32'h4142435A, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 32'h4142435A, SP4, 4'd1, 0, 0));
        // clear in FILL with a char offered: char is not stored
        tbl.push_back(mk(1, 8'h51, 0, 1, SP4, SP4, 4'd0, 0, 0));
        // empty-buffer corner cases: terminators, space, backspace all ignored
        tbl.push_back(mk(1, 8'h0D, 0, 0, SP4, SP4, 4'd0, 0, 0));
        tbl.push_back(mk(1, 8'h0A, 0, 0, SP4, SP4, 4'd0, 0, 0));
        tbl.push_back(mk(1, 8'h20, 0, 0, SP4, SP4, 4'd0, 0, 0));
        tbl.push_back(mk(1, 8'h08, 0, 0, SP4, SP4, 4'd0, 0, 0));
        // LF also terminates
        tbl.push_back(mk(1, 8'h7E, 0, 0, 32'h7E202020, SP4, 4'd1, 0, 0));
        tbl.push_back(mk(1, 8'h0A, 0, 0, 32'h7E202020, SP4, 4'd1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, SP4, SP4, 4'd0, 0, 0));

        // asynchronous reset values
        #12;
        chk("reset sentence", sentence, BLANK);
        chk_status("reset", 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            step(tbl[i].v, tbl[i].ch, tbl[i].ack, tbl[i].clr);
            chk({tag, " word0"}, {224'd0, sentence[255:224]}, {224'd0, tbl[i].w0});
            chk({tag, " word1"}, {224'd0, sentence[223:192]}, {224'd0, tbl[i].w1});
            chk({tag, " words2to7"}, {64'd0, sentence[191:0]}, {64'd0, BLANK[191:0]});
            chk_status(tag, tbl[i].wc, tbl[i].ovf, tbl[i].sv);
        end

        // 33 printable chars without spaces: 32 fill, last one overflows
        exp_s = BLANK;
        for (int k = 0; k < 32; k++) begin
            send(8'h41 + 8'(k));
            exp_s[255 - 8*k -: 8] = 8'h41 + 8'(k);
        end
        chk("full sentence", sentence, exp_s);
        chk_status("full", 4'd8, 1'b0, 1'b0);
        send(8'h61);
        chk("overflow sentence", sentence, exp_s);
        chk_status("overflow", 4'd8, 1'b1, 1'b0);
        send(8'h20);
        chk_status("space word7", 4'd8, 1'b1, 1'b0);
        send(8'h0D);
        chk("overflow done sentence", sentence, exp_s);
        chk_status("overflow done", 4'd8, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ack after overflow", sentence, BLANK);
        chk_status("ack after overflow", 4'd0, 1'b0, 1'b0);

        // DONE held 5 cycles with traffic, then ack with a char offered
        send(8'h4F); send(8'h4B); send(8'h0D);
        held_s = {32'h4F4B2020, {28{8'h20}}};
        for (int k = 0; k < 5; k++) begin
            send(8'h50 + 8'(k * 7));
            chk($sformatf("done hold %0d", k), sentence, held_s);
            chk_status($sformatf("done hold %0d", k), 4'd1, 1'b0, 1'b1);
        end
        step(1'b1, 8'h58, 1'b1, 1'b0);
        chk("ack with char", sentence, BLANK);
        chk_status("ack with char", 4'd0, 1'b0, 1'b0);

        // reset mid-word at pointer (2,3)
        send(8'h41); send(8'h41); send(8'h41); send(8'h41); send(8'h20);
        send(8'h42); send(8'h42); send(8'h42); send(8'h42); send(8'h20);
        send(8'h43); send(8'h43); send(8'h43);
        chk_status("pre-reset", 4'd3, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset sentence", sentence, BLANK);
        chk_status("async reset", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h44);
        chk("after reset word0", {224'd0, sentence[255:224]}, {224'd0, 32'h44202020});
        chk_status("after reset", 4'd1, 1'b0, 1'b0);

        // clear while in DONE
        send(8'h0D);
        chk_status("done before clear", 4'd1, 1'b0, 1'b1);
        step(1'b1, 8'h45, 1'b0, 1'b1);
        chk("clear in done", sentence, BLANK);
        chk_status("clear in done", 4'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
